// File: rtl/instr_sequencer.sv
// instr_sequencer: program memory plus issue FSM that feeds one stored
// 14-bit instruction per clock to the core's Instr port.
// Optional build macro: SEQ_LOOP_EN -- end of program wraps back to word 0
// (with a done pulse per wrap) instead of returning to IDLE.
module instr_sequencer #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter logic [13:0] NOP_INSTR = 14'h2C00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [13:0]       ld_data,
  output logic              ld_ready,
  input  logic              clr,
  input  logic              start,
  input  logic              stop,
  output logic [13:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy,
  output logic              done
);

  localparam int unsigned INSTR_W = 14;
  localparam int unsigned LEN_W   = ADDR_W + 1;
  localparam logic [LEN_W-1:0]  FULL_LEN = LEN_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR0    = '0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [INSTR_W-1:0] mem [DEPTH];

  // pc_q is one bit wider than the address so a full-depth program can
  // still reach pc_q == prog_len after its last word.
  logic [LEN_W-1:0]   pc_q, pc_next;
  logic [LEN_W-1:0]   len_q, len_next;
  logic [INSTR_W-1:0] instr_q, instr_next;
  logic               valid_q, valid_next;
  logic               busy_q, busy_next;
  logic               done_q, done_next;
  logic               mem_we;

  // Load handshake is only offered while idle, not starting, and not full.
  assign ld_ready = (state == IDLE) && !start && (len_q < FULL_LEN);

  // Next-state and next-output logic for the issue FSM.
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    len_next   = len_q;
    instr_next = instr_q;
    valid_next = valid_q;
    done_next  = 1'b0;
    mem_we     = 1'b0;

    case (state)
      IDLE: begin
        if (clr) begin
          len_next = '0;
        end else if (start) begin
          if (len_q != '0) begin
            state_next = RUN;
            instr_next = mem[ADDR0];
            valid_next = 1'b1;
            pc_next    = LEN_W'(1);
          end
        end else if (ld_valid && ld_ready) begin
          mem_we   = 1'b1;
          len_next = len_q + LEN_W'(1);
        end
      end

      RUN: begin
        if (stop) begin
          state_next = IDLE;
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
          pc_next    = '0;
        end else if (pc_q == len_q) begin
`ifdef SEQ_LOOP_EN
          instr_next = mem[ADDR0];
          valid_next = 1'b1;
          pc_next    = LEN_W'(1);
          done_next  = 1'b1;
`else
          state_next = IDLE;
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
          pc_next    = '0;
          done_next  = 1'b1;
`endif
        end else begin
          instr_next = mem[pc_q[ADDR_W-1:0]];
          valid_next = 1'b1;
          pc_next    = pc_q + LEN_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next == RUN);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      pc_q    <= pc_next;
      len_q   <= len_next;
      instr_q <= instr_next;
      valid_q <= valid_next;
      busy_q  <= busy_next;
      done_q  <= done_next;
    end
  end

  // Program memory write port; contents survive reset and clr.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[len_q[ADDR_W-1:0]] <= ld_data;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q[ADDR_W-1:0];
  assign prog_len    = len_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer (default build, loop disabled).
module tb_instr_sequencer;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;
  localparam logic [13:0] NOP    = 14'h2C00;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_valid;
  logic [13:0]       ld_data;
  logic              ld_ready;
  logic              clr;
  logic              start;
  logic              stop;
  logic [13:0]       instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   prog_len;
  logic              busy;
  logic              done;

  instr_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .clr(clr), .start(start), .stop(stop),
    .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .prog_len(prog_len), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld_valid;
    logic [13:0] ld_data;
    logic        clr;
    logic        start;
    logic        stop;
    logic        e_ready;
    logic [13:0] e_instr;
    logic        e_valid;
    logic [5:0]  e_pc;
    logic [6:0]  e_len;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  localparam int NV = 24;
  vec_t        vecs [NV];
  vec_t        exp_q [$];
  logic [13:0] word_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic vec_t mk(input logic lv, input logic [13:0] ld, input logic c,
                              input logic s, input logic p, input logic r,
                              input logic [13:0] ei, input logic ev, input logic [5:0] ep,
                              input logic [6:0] el, input logic eb, input logic ed);
    vec_t v;
    v.ld_valid = lv; v.ld_data = ld; v.clr = c; v.start = s; v.stop = p;
    v.e_ready = r; v.e_instr = ei; v.e_valid = ev; v.e_pc = ep;
    v.e_len = el; v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_data = '0; clr = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drive one vector, check the combinational ready, then check registered outputs.
  task automatic apply_vec(input int idx);
    vec_t v;
    vec_t e;
    string tag;
    v = vecs[idx];
    ld_valid = v.ld_valid; ld_data = v.ld_data; clr = v.clr;
    start = v.start; stop = v.stop;
    #1;
    tag = $sformatf("v%0d", idx);
    check({tag, ".ld_ready"}, 32'(ld_ready), 32'(v.e_ready));
    exp_q.push_back(v);
    tick();
    idle_inputs();
    e = exp_q.pop_front();
    check({tag, ".instr"}, 32'(instr), 32'(e.e_instr));
    check({tag, ".instr_valid"}, 32'(instr_valid), 32'(e.e_valid));
    check({tag, ".pc"}, 32'(pc), 32'(e.e_pc));
    check({tag, ".prog_len"}, 32'(prog_len), 32'(e.e_len));
    check({tag, ".busy"}, 32'(busy), 32'(e.e_busy));
    check({tag, ".done"}, 32'(done), 32'(e.e_done));
  endtask

  initial begin
    //            lv  data     clr st sp rdy instr    val pc len busy done
    vecs[0]  = mk(1, 14'h2C00, 0, 0, 0, 1, NOP,      0, 0, 1, 0, 0);
    vecs[1]  = mk(1, 14'h2801, 0, 0, 0, 1, NOP,      0, 0, 2, 0, 0);
    vecs[2]  = mk(1, 14'h2902, 0, 0, 0, 1, NOP,      0, 0, 3, 0, 0);
    vecs[3]  = mk(1, 14'h2A03, 0, 0, 0, 1, NOP,      0, 0, 4, 0, 0);
    vecs[4]  = mk(0, 14'h0000, 0, 1, 0, 0, 14'h2C00, 1, 1, 4, 1, 0);
    vecs[5]  = mk(0, 14'h0000, 0, 0, 0, 0, 14'h2801, 1, 2, 4, 1, 0);
    vecs[6]  = mk(0, 14'h0000, 0, 0, 0, 0, 14'h2902, 1, 3, 4, 1, 0);
    vecs[7]  = mk(0, 14'h0000, 0, 0, 0, 0, 14'h2A03, 1, 4, 4, 1, 0);
    vecs[8]  = mk(0, 14'h0000, 0, 0, 0, 0, NOP,      0, 0, 4, 0, 1);
    vecs[9]  = mk(0, 14'h0000, 0, 0, 0, 1, NOP,      0, 0, 4, 0, 0);
    vecs[10] = mk(0, 14'h0000, 0, 1, 0, 0, 14'h2C00, 1, 1, 4, 1, 0);
    vecs[11] = mk(0, 14'h0000, 0, 0, 0, 0, 14'h2801, 1, 2, 4, 1, 0);
    vecs[12] = mk(0, 14'h0000, 0, 0, 1, 0, NOP,      0, 0, 4, 0, 0);
    vecs[13] = mk(0, 14'h0000, 0, 1, 0, 0, 14'h2C00, 1, 1, 4, 1, 0);
    vecs[14] = mk(0, 14'h0000, 0, 0, 1, 0, NOP,      0, 0, 4, 0, 0);
    vecs[15] = mk(0, 14'h0000, 1, 0, 0, 1, NOP,      0, 0, 0, 0, 0);
    vecs[16] = mk(0, 14'h0000, 0, 1, 0, 0, NOP,      0, 0, 0, 0, 0);
    vecs[17] = mk(1, 14'h1234, 1, 0, 0, 1, NOP,      0, 0, 0, 0, 0);
    vecs[18] = mk(1, 14'h0AAA, 0, 0, 0, 1, NOP,      0, 0, 1, 0, 0);
    vecs[19] = mk(0, 14'h0000, 0, 1, 0, 0, 14'h0AAA, 1, 1, 1, 1, 0);
    vecs[20] = mk(1, 14'h3333, 0, 0, 0, 0, NOP,      0, 0, 1, 0, 1);
    vecs[21] = mk(0, 14'h0000, 0, 1, 0, 0, 14'h0AAA, 1, 1, 1, 1, 0);
    vecs[22] = mk(0, 14'h0000, 0, 0, 1, 0, NOP,      0, 0, 1, 0, 0);
    vecs[23] = mk(0, 14'h0000, 0, 0, 0, 1, NOP,      0, 0, 1, 0, 0);

    // Reset state.
    do_reset();
    check("rst.instr", 32'(instr), 32'(NOP));
    check("rst.instr_valid", 32'(instr_valid), 32'(0));
    check("rst.pc", 32'(pc), 32'(0));
    check("rst.prog_len", 32'(prog_len), 32'(0));
    check("rst.busy", 32'(busy), 32'(0));
    check("rst.done", 32'(done), 32'(0));

    for (int i = 0; i < NV; i++) apply_vec(i);

    // Fill to DEPTH, confirm the extra word is refused, then replay all words.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1;
      ld_data  = 14'(i * 37 + 5);
      #1;
      check($sformatf("fill%0d.ld_ready", i), 32'(ld_ready), 32'(1));
      word_q.push_back(ld_data);
      tick();
    end
    ld_valid = 1'b1;
    ld_data  = 14'h3FFF;
    #1;
    check("full.prog_len", 32'(prog_len), 32'(DEPTH));
    check("full.ld_ready", 32'(ld_ready), 32'(0));
    tick();
    check("full.prog_len_hold", 32'(prog_len), 32'(DEPTH));
    idle_inputs();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [13:0] w;
      if (i != 0) tick();
      w = word_q.pop_front();
      check($sformatf("full.instr%0d", i), 32'(instr), 32'(w));
      check($sformatf("full.valid%0d", i), 32'(instr_valid), 32'(1));
      check($sformatf("full.busy%0d", i), 32'(busy), 32'(1));
    end
    tick();
    check("full_end.instr", 32'(instr), 32'(NOP));
    check("full_end.instr_valid", 32'(instr_valid), 32'(0));
    check("full_end.done", 32'(done), 32'(1));
    check("full_end.busy", 32'(busy), 32'(0));
    tick();
    check("full_end.done_pulse", 32'(done), 32'(0));

    // Reset in the middle of a 3-word run.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = 14'(14'h2100 + i);
      tick();
    end
    idle_inputs();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("midrst.pre_instr", 32'(instr), 32'(14'h2101));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.instr", 32'(instr), 32'(NOP));
    check("midrst.instr_valid", 32'(instr_valid), 32'(0));
    check("midrst.busy", 32'(busy), 32'(0));
    check("midrst.prog_len", 32'(prog_len), 32'(0));
    check("midrst.pc", 32'(pc), 32'(0));
    check("midrst.done", 32'(done), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction-issue front end for the 14-bit processor core. Holds a small program memory, loaded by a valid/ready write port. On `start` it drives one stored instruction word per clock onto the processor's `Instr` input, so the core runs self-contained without a bench-driven instruction stream. Instruction format is the core's: `{opcode[3:0], reg[1:0], imm[7:0]}`. The sequencer does not decode it.

## Interface
- `DEPTH`, 64: program memory words; power of two, 2..256.
- `ADDR_W`, 6: $clog2(DEPTH).
- `NOP_INSTR`, 14'h2C00: filler word driven whenever no program word is issued.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `ld_valid`  in  1  load word offered.
- `ld_data`  in  14  word to append to the program.
- `ld_ready`  out  1  load accepted this cycle when high with `ld_valid`.
- `clr`  in  1  discard the loaded program; honoured only in IDLE.
- `start`  in  1  begin issuing; honoured only in IDLE.
- `stop`  in  1  abort issue; honoured only in RUN.
- `instr`  out  14  registered instruction to the core's `Instr` port.
- `instr_valid`  out  1  `instr` holds a program word, not the filler.
- `pc`  out  ADDR_W  index of the next word to issue.
- `prog_len`  out  ADDR_W+1  number of words loaded.
- `busy`  out  1  state is RUN.
- `done`  out  1  one-cycle pulse when a program completes normally.

## Operation
- States: IDLE, RUN.
- Reset: state IDLE, `instr`=NOP_INSTR, `instr_valid`=0, `pc`=0, `prog_len`=0, `busy`=0, `done`=0. Memory contents are not cleared.
- Loading:
  - `ld_ready` = IDLE & !start & (prog_len < DEPTH). It is combinational.
  - Handshake (`ld_valid` & `ld_ready`) writes `mem[prog_len]` and increments `prog_len`.
  - Full (`prog_len`==DEPTH): `ld_ready`=0 and the word is not consumed.
- `clr` in IDLE: `prog_len`<=0. If `clr` and `ld_valid` arrive together, `clr` wins and no write occurs.
- `start` in IDLE:
  - With `prog_len`==0: ignored. No state change, no `done`.
  - Otherwise: state<=RUN, `instr`<=mem[0], `instr_valid`<=1, `pc`<=1.
- Each edge in RUN:
  - `stop`: state<=IDLE, `instr`<=NOP_INSTR, `instr_valid`<=0, `pc`<=0. No `done`.
  - Else if `pc`==`prog_len`: end of program (see Configuration).
  - Else: `instr`<=mem[pc], `instr_valid`<=1, `pc`<=pc+1.
- `start`, `clr` and `ld_valid` are ignored in RUN.
- Program memory is retained across runs. A second `start` replays the same program.
- `busy` is registered and equals (state==RUN).

## Timing
- Start latency: the first program word is on `instr` the cycle after `start` is sampled.
- Issue rate: one word per cycle, no gaps. A program of length N occupies `instr` for exactly N consecutive cycles.
- End of program (loop disabled): on the edge after the last word,
  - `instr`=NOP_INSTR and `instr_valid`=0;
  - `done`=1 for that one cycle;
  - state is IDLE.
- `stop`: filler is on `instr` in the cycle after `stop` is sampled. A `stop` coinciding with end of program takes priority, and `done` stays 0.
- `rst` mid-RUN: all outputs take reset values at that edge. `prog_len` returns to 0, so the program must be reloaded.
- Memory read is synchronous into the `instr` register. There is no combinational path from any input to `instr`.

## Configuration
- `SEQ_LOOP_EN` defined: at end of program the sequencer wraps.
  - `instr`<=mem[0], `pc`<=1, state remains RUN.
  - `done` pulses for one cycle on every wrap.
  - Only `stop` or `rst` ends issue.
- `SEQ_LOOP_EN` undefined: end of program returns to IDLE, as in Timing.

## Test plan
- Reset, then load 14'h2C00, 14'h2801, 14'h2902, 14'h2A03, then `start`. `instr` shows those four words on four consecutive cycles with `instr_valid`=1. The next cycle has `instr`=14'h2C00, `instr_valid`=0, `done`=1. `busy` is high for exactly 4 cycles.
- Load DEPTH words with `ld_valid` held high. `ld_ready` drops after the DEPTH-th handshake, `prog_len`=DEPTH, and a further word is not written.
- Load 4 words, `start`, assert `stop` on the cycle the second word is visible. The next cycle has `instr`=NOP_INSTR, `pc`=0, no `done` pulse. A following `start` replays from word 0.
- `start` with `prog_len`=0 leaves state IDLE and `instr_valid`=0. Assert `clr` together with `ld_valid`: `prog_len`=0 and no write occurs.
- Assert `rst` mid-RUN of a 3-word program: next cycle `instr`=NOP_INSTR, `busy`=0, `prog_len`=0.
- With `SEQ_LOOP_EN` defined, run a 2-word program A,B. The sequence A,B,A,B,… is issued with `done` pulsing on each return to A, until `stop`.
